vdp_bg_render: RTL and testbench
================================

# vdp_bg_render

Background (tile-layer) line renderer for the VDP. On each `start` pulse it fetches the 32 name-table entries and pattern rows for one scanline from VRAM, applies scroll and flips, and writes 256 pixels into the line buffer's write port (port 1). The sprite stage overlays these pixels afterwards, and scan-out reads them (port 2) on the following line.

## Interface
Parameters: none (constants live in the package).

- `clk` in 1: VDP clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle pulse requesting render of `line`. Ignored while `busy`.
- `line` in 8: active scanline, 0..191.
- `hscroll` in 8: horizontal scroll.
- `vscroll` in 8: vertical scroll.
- `hscroll_lock_top` in 1: forces effective hscroll to 0 for lines 0..15.
- `nt_base` in 3: name-table base, VRAM address bits [13:11].
- `vram_addr` out 14: VRAM read address.
- `vram_rddata` in 8: VRAM data. Valid exactly one cycle after `vram_addr`.
- `lb_idx` out 8: line-buffer pixel index.
- `lb_wrdata` out 8: pixel word `{2'b0, prio, pal, color[3:0]}`.
- `lb_wren` out 1: line-buffer write strobe.
- `busy` out 1: render in progress.
- `done` out 1: one-cycle pulse after the last pixel write.

## Operation
- **Capture.** On `start` while idle, latch `line`, `hscroll`, `vscroll`, `hscroll_lock_top` and `nt_base`. These stay constant for the whole line.
- **Row math.**
  - y = line + vscroll, as a 9-bit value.
  - Subtract 224 while y ≥ 224, at most twice.
  - tile_row = y[7:3]; fine_y = y[2:0].
- **Tile slots.** Column c (0..31) occupies slot k = 0..7. Slots 0..5 issue VRAM reads; slots 6..7 issue none.
  - k=0: name-table low byte, {nt_base, tile_row, c, 1'b0}.
  - k=1: name-table high byte, {nt_base, tile_row, c, 1'b1}.
  - Entry layout: [8:0] tile index, [9] hflip, [10] vflip, [11] palette, [12] priority, [15:13] ignored.
  - k=2..5: pattern planes 0..3, {tile, row, plane}, where row = vflip ? 7-fine_y : fine_y.
- **Pixel p of column c** (p = 0..7):
  - color bit n = plane_n[hflip ? p : 7-p].
  - Written to lb_idx = (c·8 + p + hs) mod 256, where hs is the effective hscroll.
  - Priority and palette bits are passed through even when color = 0.
- **FSM.**
  - IDLE: `start` → FETCH.
  - FETCH: slot counter 0..255; column = counter[7:3], k = counter[2:0].
  - DRAIN: after the final fetch slot, until the last pixel is written.
  - DONE: pulse `done` for one cycle → IDLE.
- `vram_addr` holds its last value when no read is issued. VRAM reads carry no enable; only the address matters.

## Timing
- Cycle 0 is the first cycle after the `start` sample. `busy` is high from cycle 0.
- Column c, slot k address is issued at cycle 8c+k. Its data is sampled at 8c+k+1.
- Plane 3 data arrives at 8c+6. The shifter loads at 8c+7.
- Pixels 0..7 of column c are written at cycles 8c+8 .. 8c+15, with `lb_wren` high. Writes are therefore back-to-back from cycle 8 to 263.
- `done` is high at cycle 264. `busy` falls in the same cycle.
- A new `start` is accepted from cycle 265.
- `start` while busy is ignored. No restart, no queueing.
- Reset mid-line: all state returns to IDLE immediately and the partial line is abandoned. The line-buffer contents are don't-care.
- Reset values:
  - `busy`, `done`, `lb_wren`: 0.
  - `vram_addr`: 0.
  - `lb_idx`: 0.
  - `lb_wrdata`: 0.

## Structure
- **Shared package `vdp_pkg`** holds:
  - Name-table entry field positions.
  - `VDP_ROWS` = 224.
  - `HSCROLL_LOCK_LINES` = 16.
  - The pixel-word bit layout (shared with the sprite stage and scan-out).
- **Sub-module `bg_pixel_shifter`** holds the four plane registers plus flip, palette, priority and base index. It is loaded on one cycle and emits 8 consecutive `lb_idx`/`lb_wrdata`/`lb_wren` beats.
- The top level keeps the FSM, slot counter, row math and address generation.

## Test plan
- **No scroll, no flip.** line=0, scroll 0, tile 1 at column 0, planes 0xFF,0x00,0x00,0x00 → lb_idx 0..7 get wrdata 0x01. `done` at cycle 264; exactly 256 writes total.
- **Horizontal scroll wrap.** hscroll=250, column 31 → its pixels land at lb_idx 242..249. Column 0 starts at 250, and its pixel 6 wraps to index 0.
- **Vertical scroll wrap.** line=100, vscroll=200 → y=76, tile_row 9, fine_y 4; check the addresses. vscroll=255, line=191 → y=222.
- **Flips and attribute bits.** Entry 0x1E05 (hflip, vflip, pal, prio), fine_y 0 → pattern row 7 is fetched, pixel order is reversed, and wrdata[5:4] = 2'b11.
- **Scroll lock and start handling.** hscroll_lock_top=1, hscroll=8: line 15 → column 0 at index 0; line 16 → column 0 at index 8. A `start` during busy is ignored. Reset at cycle 100 → `busy`=0 and `lb_wren`=0 with no further writes.

Source files
------------

// File: rtl/vdp_pkg.sv
// Shared VDP constants: name-table entry fields, row wrap, scroll lock and the
// line-buffer pixel word layout used by the background, sprite and scan-out stages.
package vdp_pkg;

  localparam int VDP_ROWS           = 224;
  localparam int HSCROLL_LOCK_LINES = 16;

  // Name-table entry bit positions (16-bit entry, [15:13] ignored)
  localparam int NT_TILE_MSB  = 8;
  localparam int NT_HFLIP_BIT = 9;
  localparam int NT_VFLIP_BIT = 10;
  localparam int NT_PAL_BIT   = 11;
  localparam int NT_PRIO_BIT  = 12;

  // Pixel word: {2'b0, prio, pal, color[3:0]}
  localparam int PIX_COLOR_LSB = 0;
  localparam int PIX_COLOR_W   = 4;
  localparam int PIX_PAL_BIT   = 4;
  localparam int PIX_PRIO_BIT  = 5;

  typedef enum logic [1:0] {
    BG_IDLE,
    BG_FETCH,
    BG_DRAIN,
    BG_DONE
  } bg_state_e;

  function automatic logic [7:0] pack_pixel(input logic prio, input logic pal,
                                            input logic [PIX_COLOR_W-1:0] color);
    logic [7:0] w;
    w = '0;
    w[PIX_COLOR_LSB +: PIX_COLOR_W] = color;
    w[PIX_PAL_BIT]  = pal;
    w[PIX_PRIO_BIT] = prio;
    return w;
  endfunction

endpackage

// File: rtl/bg_pixel_shifter.sv
// Holds one tile column's four pattern planes and attributes; after a load it
// emits eight consecutive line-buffer write beats.
module bg_pixel_shifter
  import vdp_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [3:0][7:0] planes,
  input  logic            hflip,
  input  logic            pal,
  input  logic            prio,
  input  logic [7:0]      base_idx,
  output logic [7:0]      lb_idx,
  output logic [7:0]      lb_wrdata,
  output logic            lb_wren
);

  logic [3:0][7:0] planes_q, planes_d;
  logic            hflip_q, hflip_d;
  logic            pal_q, pal_d;
  logic            prio_q, prio_d;
  logic [7:0]      base_q, base_d;
  logic [2:0]      pix_q, pix_d;
  logic            active_q, active_d;
  logic [7:0]      idx_q, idx_d;
  logic [7:0]      data_q, data_d;
  logic            wren_q, wren_d;

  function automatic logic [PIX_COLOR_W-1:0] pix_color(input logic [3:0][7:0] pl,
                                                       input logic hf,
                                                       input logic [2:0] p);
    logic [2:0]             b;
    logic [PIX_COLOR_W-1:0] c;
    b = hf ? p : 3'd7 - p;
    for (int n = 0; n < PIX_COLOR_W; n++) c[n] = pl[n][b];
    return c;
  endfunction

  // A load emits pixel 0 straight from the inputs so columns stay back-to-back.
  always_comb begin
    planes_d = planes_q;
    hflip_d  = hflip_q;
    pal_d    = pal_q;
    prio_d   = prio_q;
    base_d   = base_q;
    pix_d    = pix_q;
    active_d = active_q;
    idx_d    = idx_q;
    data_d   = data_q;
    wren_d   = 1'b0;
    if (load) begin
      planes_d = planes;
      hflip_d  = hflip;
      pal_d    = pal;
      prio_d   = prio;
      base_d   = base_idx;
      pix_d    = 3'd1;
      active_d = 1'b1;
      wren_d   = 1'b1;
      idx_d    = base_idx;
      data_d   = pack_pixel(prio, pal, pix_color(planes, hflip, 3'd0));
    end else if (active_q) begin
      wren_d   = 1'b1;
      idx_d    = base_q + {5'd0, pix_q};
      data_d   = pack_pixel(prio_q, pal_q, pix_color(planes_q, hflip_q, pix_q));
      pix_d    = pix_q + 3'd1;
      active_d = (pix_q != 3'd7);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      planes_q <= '0;
      hflip_q  <= 1'b0;
      pal_q    <= 1'b0;
      prio_q   <= 1'b0;
      base_q   <= '0;
      pix_q    <= '0;
      active_q <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
      wren_q   <= 1'b0;
    end else begin
      planes_q <= planes_d;
      hflip_q  <= hflip_d;
      pal_q    <= pal_d;
      prio_q   <= prio_d;
      base_q   <= base_d;
      pix_q    <= pix_d;
      active_q <= active_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      wren_q   <= wren_d;
    end
  end

  assign lb_idx    = idx_q;
  assign lb_wrdata = data_q;
  assign lb_wren   = wren_q;

endmodule

// File: rtl/vdp_bg_render.sv
// Background tile-layer line renderer: fetches name-table entries and pattern
// planes for one scanline from VRAM and streams 256 pixels into the line buffer.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// BG_IDLE  | waiting for start; scroll/line/base captured on acceptance
// BG_FETCH | 256 slots, column = slot[7:3], k = slot[2:0]
// BG_DRAIN | last column's 8 pixels leave the shifter
// BG_DONE  | one-cycle done pulse, back to idle
module vdp_bg_render
  import vdp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  line,
  input  logic [7:0]  hscroll,
  input  logic [7:0]  vscroll,
  input  logic        hscroll_lock_top,
  input  logic [2:0]  nt_base,
  output logic [13:0] vram_addr,
  input  logic [7:0]  vram_rddata,
  output logic [7:0]  lb_idx,
  output logic [7:0]  lb_wrdata,
  output logic        lb_wren,
  output logic        busy,
  output logic        done
);

  bg_state_e state_q, state_d;
  logic [7:0]      slot_q, slot_d;
  logic [7:0]      line_q, hscroll_q, vscroll_q;
  logic            lock_q;
  logic [2:0]      nt_base_q;
  logic [7:0]      nt_lo_q;
  logic [4:0]      nt_hi_q;
  logic [3:0][7:0] planes_q;
  logic [13:0]     addr_hold_q;

  logic [4:0]  col;
  logic [2:0]  k;
  logic [8:0]  y_raw, y_one, y_wr;
  logic [4:0]  tile_row;
  logic [2:0]  fine_y, pat_row;
  logic [4:0]  entry_hi;
  logic [8:0]  tile;
  logic [7:0]  hs_eff;
  logic [13:0] addr_cur;
  logic        shift_load;

  assign col = slot_q[7:3];
  assign k   = slot_q[2:0];

  // Line + vscroll can reach 446, so one or two row wraps bring it into 0..223.
  always_comb begin
    y_raw = {1'b0, line_q} + {1'b0, vscroll_q};
    y_one = (y_raw >= 9'(VDP_ROWS)) ? y_raw - 9'(VDP_ROWS) : y_raw;
    y_wr  = (y_one >= 9'(VDP_ROWS)) ? y_one - 9'(VDP_ROWS) : y_one;
  end

  assign tile_row = y_wr[7:3];
  assign fine_y   = y_wr[2:0];

  // The high entry byte is still on the bus during slot 2, so bypass it there.
  assign entry_hi = (k == 3'd2) ? vram_rddata[4:0] : nt_hi_q;
  assign tile     = {entry_hi[NT_TILE_MSB-8], nt_lo_q};
  assign pat_row  = entry_hi[NT_VFLIP_BIT-8] ? 3'd7 - fine_y : fine_y;

  assign hs_eff = (lock_q && (line_q < 8'(HSCROLL_LOCK_LINES))) ? 8'd0 : hscroll_q;

  always_comb begin
    addr_cur = addr_hold_q;
    if (state_q == BG_FETCH) begin
      case (k)
        3'd0:                      addr_cur = {nt_base_q, tile_row, col, 1'b0};
        3'd1:                      addr_cur = {nt_base_q, tile_row, col, 1'b1};
        3'd2, 3'd3, 3'd4, 3'd5:    addr_cur = {tile, pat_row, k[1:0] - 2'd2};
        default:                   addr_cur = addr_hold_q;
      endcase
    end
  end

  assign vram_addr  = addr_cur;
  assign shift_load = (state_q == BG_FETCH) && (k == 3'd7);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    case (state_q)
      BG_IDLE: begin
        if (start) begin
          state_d = BG_FETCH;
          slot_d  = 8'd0;
        end
      end
      BG_FETCH: begin
        slot_d = slot_q + 8'd1;
        if (slot_q == 8'd255) state_d = BG_DRAIN;
      end
      BG_DRAIN: begin
        slot_d = slot_q + 8'd1;
        if (slot_q == 8'd7) state_d = BG_DONE;
      end
      BG_DONE: state_d = BG_IDLE;
      default: state_d = BG_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BG_IDLE;
      slot_q      <= '0;
      line_q      <= '0;
      hscroll_q   <= '0;
      vscroll_q   <= '0;
      lock_q      <= 1'b0;
      nt_base_q   <= '0;
      nt_lo_q     <= '0;
      nt_hi_q     <= '0;
      planes_q    <= '0;
      addr_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      addr_hold_q <= addr_cur;
      if (state_q == BG_IDLE && start) begin
        line_q    <= line;
        hscroll_q <= hscroll;
        vscroll_q <= vscroll;
        lock_q    <= hscroll_lock_top;
        nt_base_q <= nt_base;
      end
      if (state_q == BG_FETCH) begin
        if (k == 3'd1) nt_lo_q <= vram_rddata;
        if (k == 3'd2) nt_hi_q <= vram_rddata[4:0];
        if (k >= 3'd3 && k <= 3'd6) planes_q[k[1:0] + 2'd1] <= vram_rddata;
      end
    end
  end

  bg_pixel_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (shift_load),
    .planes    (planes_q),
    .hflip     (nt_hi_q[NT_HFLIP_BIT-8]),
    .pal       (nt_hi_q[NT_PAL_BIT-8]),
    .prio      (nt_hi_q[NT_PRIO_BIT-8]),
    .base_idx  ({col, 3'b000} + hs_eff),
    .lb_idx    (lb_idx),
    .lb_wrdata (lb_wrdata),
    .lb_wren   (lb_wren)
  );

  assign busy = (state_q == BG_FETCH) || (state_q == BG_DRAIN);
  assign done = (state_q == BG_DONE);

endmodule

// File: tb/tb_vdp_bg_render.sv
// Directed bench for vdp_bg_render with a registered-read VRAM model and a
// captured line buffer; expected values are hand-computed per scenario.
module tb_vdp_bg_render;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  line = '0, hscroll = '0, vscroll = '0;
  logic        hscroll_lock_top = 1'b0;
  logic [2:0]  nt_base = '0;
  logic [13:0] vram_addr;
  logic [7:0]  vram_rddata = '0;
  logic [7:0]  lb_idx, lb_wrdata;
  logic        lb_wren, busy, done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:16383];
  logic [7:0]  lb_mem [0:255];
  logic [13:0] addr_log [0:299];
  logic        busy_log [0:299];
  int          widx_log [0:299];
  int          wr_count, done_cyc, first_wr, last_wr;

  always #5 clk = ~clk;

  always @(posedge clk) vram_rddata <= mem[vram_addr];

  vdp_bg_render dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .line             (line),
    .hscroll          (hscroll),
    .vscroll          (vscroll),
    .hscroll_lock_top (hscroll_lock_top),
    .nt_base          (nt_base),
    .vram_addr        (vram_addr),
    .vram_rddata      (vram_rddata),
    .lb_idx           (lb_idx),
    .lb_wrdata        (lb_wrdata),
    .lb_wren          (lb_wren),
    .busy             (busy),
    .done             (done)
  );

  task automatic clear_mem();
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
  endtask

  // Called at a negedge; start is high for that half cycle so cycle 0 follows.
  task automatic run_line(input logic [7:0] ln, input logic [7:0] hs, input logic [7:0] vs,
                          input logic lk, input logic [2:0] nt, input int ign_cyc);
    for (int i = 0; i < 256; i++) lb_mem[i] = 8'hEE;
    for (int i = 0; i < 300; i++) begin
      addr_log[i] = '0; busy_log[i] = 1'b0; widx_log[i] = -1;
    end
    wr_count = 0; done_cyc = -1; first_wr = -1; last_wr = -1;
    line = ln; hscroll = hs; vscroll = vs; hscroll_lock_top = lk; nt_base = nt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      addr_log[cyc] = vram_addr;
      busy_log[cyc] = busy;
      if (lb_wren) begin
        lb_mem[lb_idx] = lb_wrdata;
        widx_log[cyc] = int'(lb_idx);
        wr_count++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      start = (cyc == ign_cyc);
      if (cyc == ign_cyc) line = 8'd50;
      if (done_cyc >= 0 && cyc == done_cyc + 1) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_in_reset: got %b exp 0", busy); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
    checks++; if (lb_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b exp 0", lb_wren); end
    checks++; if (vram_addr !== 14'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", vram_addr); end
    checks++; if (lb_idx !== 8'h0) begin errors++; $display("FAIL reset_idx: got %h exp 0", lb_idx); end
    checks++; if (lb_wrdata !== 8'h0) begin errors++; $display("FAIL reset_wrdata: got %h exp 0", lb_wrdata); end
  endtask

  task automatic test_no_scroll();
    clear_mem();
    mem[14'h800] = 8'h01; mem[14'h801] = 8'h00;
    mem[14'h020] = 8'hFF;
    run_line(8'd0, 8'd0, 8'd0, 1'b0, 3'd1, -1);
    checks++; if (busy_log[0] !== 1'b1) begin errors++; $display("FAIL ns_busy_c0: got %b exp 1", busy_log[0]); end
    checks++; if (done_cyc !== 264) begin errors++; $display("FAIL ns_done_cyc: got %0d exp 264", done_cyc); end
    checks++; if (busy_log[264] !== 1'b0) begin errors++; $display("FAIL ns_busy_c264: got %b exp 0", busy_log[264]); end
    checks++; if (wr_count !== 256) begin errors++; $display("FAIL ns_wr_count: got %0d exp 256", wr_count); end
    checks++; if (first_wr !== 8) begin errors++; $display("FAIL ns_first_wr: got %0d exp 8", first_wr); end
    checks++; if (last_wr !== 263) begin errors++; $display("FAIL ns_last_wr: got %0d exp 263", last_wr); end
    checks++; if (addr_log[0] !== 14'h800) begin errors++; $display("FAIL ns_addr0: got %h exp 800", addr_log[0]); end
    checks++; if (addr_log[1] !== 14'h801) begin errors++; $display("FAIL ns_addr1: got %h exp 801", addr_log[1]); end
    checks++; if (addr_log[2] !== 14'h020) begin errors++; $display("FAIL ns_addr2: got %h exp 020", addr_log[2]); end
    checks++; if (addr_log[5] !== 14'h023) begin errors++; $display("FAIL ns_addr5: got %h exp 023", addr_log[5]); end
    checks++; if (addr_log[7] !== 14'h023) begin errors++; $display("FAIL ns_addr_hold: got %h exp 023", addr_log[7]); end
    checks++; if (addr_log[8] !== 14'h802) begin errors++; $display("FAIL ns_addr8: got %h exp 802", addr_log[8]); end
    for (int i = 0; i < 256; i++) begin
      logic [7:0] exp_px;
      exp_px = (i < 8) ? 8'h01 : 8'h00;
      checks++;
      if (lb_mem[i] !== exp_px) begin errors++; $display("FAIL ns_pix[%0d]: got %h exp %h", i, lb_mem[i], exp_px); end
    end
  endtask

  task automatic test_hscroll_wrap();
    clear_mem();
    mem[14'h800] = 8'h01; mem[14'h020] = 8'hFF;
    mem[14'h83E] = 8'h02; mem[14'h041] = 8'hFF;
    run_line(8'd0, 8'd250, 8'd0, 1'b0, 3'd1, -1);
    for (int i = 242; i <= 249; i++) begin
      checks++; if (lb_mem[i] !== 8'h02) begin errors++; $display("FAIL hs_col31[%0d]: got %h exp 02", i, lb_mem[i]); end
    end
    checks++; if (lb_mem[250] !== 8'h01) begin errors++; $display("FAIL hs_col0_250: got %h exp 01", lb_mem[250]); end
    checks++; if (lb_mem[0] !== 8'h01) begin errors++; $display("FAIL hs_col0_0: got %h exp 01", lb_mem[0]); end
    checks++; if (lb_mem[1] !== 8'h01) begin errors++; $display("FAIL hs_col0_1: got %h exp 01", lb_mem[1]); end
    checks++; if (lb_mem[2] !== 8'h00) begin errors++; $display("FAIL hs_col1_2: got %h exp 00", lb_mem[2]); end
    checks++; if (widx_log[8] !== 250) begin errors++; $display("FAIL hs_idx_c8: got %0d exp 250", widx_log[8]); end
    checks++; if (widx_log[14] !== 0) begin errors++; $display("FAIL hs_idx_c14: got %0d exp 0", widx_log[14]); end
    checks++; if (wr_count !== 256) begin errors++; $display("FAIL hs_wr_count: got %0d exp 256", wr_count); end
  endtask

  task automatic test_vscroll_wrap();
    clear_mem();
    mem[14'hA40] = 8'h03;
    run_line(8'd100, 8'd0, 8'd200, 1'b0, 3'd1, -1);
    checks++; if (addr_log[0] !== 14'hA40) begin errors++; $display("FAIL vs_addr0: got %h exp A40", addr_log[0]); end
    checks++; if (addr_log[1] !== 14'hA41) begin errors++; $display("FAIL vs_addr1: got %h exp A41", addr_log[1]); end
    checks++; if (addr_log[2] !== 14'h070) begin errors++; $display("FAIL vs_addr2: got %h exp 070", addr_log[2]); end
    checks++; if (addr_log[3] !== 14'h071) begin errors++; $display("FAIL vs_addr3: got %h exp 071", addr_log[3]); end
    checks++; if (addr_log[5] !== 14'h073) begin errors++; $display("FAIL vs_addr5: got %h exp 073", addr_log[5]); end
    checks++; if (addr_log[8] !== 14'hA42) begin errors++; $display("FAIL vs_addr8: got %h exp A42", addr_log[8]); end
    clear_mem();
    run_line(8'd191, 8'd0, 8'd255, 1'b0, 3'd0, -1);
    checks++; if (addr_log[0] !== 14'h6C0) begin errors++; $display("FAIL vs222_addr0: got %h exp 6C0", addr_log[0]); end
    checks++; if (addr_log[1] !== 14'h6C1) begin errors++; $display("FAIL vs222_addr1: got %h exp 6C1", addr_log[1]); end
    checks++; if (addr_log[2] !== 14'h018) begin errors++; $display("FAIL vs222_addr2: got %h exp 018", addr_log[2]); end
  endtask

  task automatic test_flips();
    logic [7:0] exp_f [0:7];
    exp_f[0] = 8'h31; exp_f[1] = 8'h30; exp_f[2] = 8'h30; exp_f[3] = 8'h30;
    exp_f[4] = 8'h30; exp_f[5] = 8'h30; exp_f[6] = 8'h30; exp_f[7] = 8'h34;
    clear_mem();
    mem[14'h800] = 8'h05; mem[14'h801] = 8'h1E;
    mem[14'h0BC] = 8'h01; mem[14'h0BE] = 8'h80;
    run_line(8'd0, 8'd0, 8'd0, 1'b0, 3'd1, -1);
    checks++; if (addr_log[2] !== 14'h0BC) begin errors++; $display("FAIL fl_addr2: got %h exp 0BC", addr_log[2]); end
    checks++; if (addr_log[5] !== 14'h0BF) begin errors++; $display("FAIL fl_addr5: got %h exp 0BF", addr_log[5]); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (lb_mem[i] !== exp_f[i]) begin errors++; $display("FAIL fl_pix[%0d]: got %h exp %h", i, lb_mem[i], exp_f[i]); end
    end
    checks++; if (lb_mem[8] !== 8'h00) begin errors++; $display("FAIL fl_pix8: got %h exp 00", lb_mem[8]); end
  endtask

  task automatic test_scroll_lock();
    clear_mem();
    mem[14'h840] = 8'h01; mem[14'h03C] = 8'hFF;
    run_line(8'd15, 8'd8, 8'd0, 1'b1, 3'd1, -1);
    checks++; if (addr_log[0] !== 14'h840) begin errors++; $display("FAIL lk15_addr0: got %h exp 840", addr_log[0]); end
    checks++; if (lb_mem[0] !== 8'h01) begin errors++; $display("FAIL lk15_pix0: got %h exp 01", lb_mem[0]); end
    checks++; if (lb_mem[7] !== 8'h01) begin errors++; $display("FAIL lk15_pix7: got %h exp 01", lb_mem[7]); end
    checks++; if (lb_mem[8] !== 8'h00) begin errors++; $display("FAIL lk15_pix8: got %h exp 00", lb_mem[8]); end
    clear_mem();
    mem[14'h880] = 8'h01; mem[14'h020] = 8'hFF;
    run_line(8'd16, 8'd8, 8'd0, 1'b1, 3'd1, -1);
    checks++; if (lb_mem[0] !== 8'h00) begin errors++; $display("FAIL lk16_pix0: got %h exp 00", lb_mem[0]); end
    checks++; if (lb_mem[8] !== 8'h01) begin errors++; $display("FAIL lk16_pix8: got %h exp 01", lb_mem[8]); end
    checks++; if (lb_mem[15] !== 8'h01) begin errors++; $display("FAIL lk16_pix15: got %h exp 01", lb_mem[15]); end
    checks++; if (lb_mem[16] !== 8'h00) begin errors++; $display("FAIL lk16_pix16: got %h exp 00", lb_mem[16]); end
  endtask

  task automatic test_start_ignored();
    clear_mem();
    run_line(8'd0, 8'd0, 8'd0, 1'b0, 3'd1, 50);
    checks++; if (addr_log[64] !== 14'h810) begin errors++; $display("FAIL ign_addr64: got %h exp 810", addr_log[64]); end
    checks++; if (done_cyc !== 264) begin errors++; $display("FAIL ign_done_cyc: got %0d exp 264", done_cyc); end
    checks++; if (wr_count !== 256) begin errors++; $display("FAIL ign_wr_count: got %0d exp 256", wr_count); end
    checks++; if (busy_log[265] !== 1'b0) begin errors++; $display("FAIL ign_busy_c265: got %b exp 0", busy_log[265]); end
  endtask

  task automatic test_back_to_back();
    clear_mem();
    mem[14'h800] = 8'h01; mem[14'h020] = 8'hFF;
    run_line(8'd0, 8'd0, 8'd0, 1'b0, 3'd1, -1);
    run_line(8'd0, 8'd16, 8'd0, 1'b0, 3'd1, -1);
    checks++; if (busy_log[0] !== 1'b1) begin errors++; $display("FAIL b2b_busy_c0: got %b exp 1", busy_log[0]); end
    checks++; if (done_cyc !== 264) begin errors++; $display("FAIL b2b_done_cyc: got %0d exp 264", done_cyc); end
    checks++; if (lb_mem[16] !== 8'h01) begin errors++; $display("FAIL b2b_pix16: got %h exp 01", lb_mem[16]); end
    checks++; if (lb_mem[0] !== 8'h00) begin errors++; $display("FAIL b2b_pix0: got %h exp 00", lb_mem[0]); end
  endtask

  task automatic test_reset_midline();
    int late_wr;
    int late_busy;
    clear_mem();
    line = 8'd0; hscroll = 8'd0; vscroll = 8'd0; hscroll_lock_top = 1'b0; nt_base = 3'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (lb_wren !== 1'b1) begin errors++; $display("FAIL rm_wren_c100: got %b exp 1", lb_wren); end
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b exp 0", busy); end
    checks++; if (lb_wren !== 1'b0) begin errors++; $display("FAIL rm_wren: got %b exp 0", lb_wren); end
    @(negedge clk);
    reset = 1'b0;
    late_wr = 0; late_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (lb_wren) late_wr++;
      if (busy) late_busy++;
    end
    checks++; if (late_wr !== 0) begin errors++; $display("FAIL rm_late_writes: got %0d exp 0", late_wr); end
    checks++; if (late_busy !== 0) begin errors++; $display("FAIL rm_late_busy: got %0d exp 0", late_busy); end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_no_scroll();
    test_hscroll_wrap();
    test_vscroll_wrap();
    test_flips();
    test_scroll_lock();
    test_start_ignored();
    test_back_to_back();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
